// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_if
// Brief    : CPU-side bus of the NES memory controller (address, data, strobes, busy)
// Revision : 1.0
// ============================================================================
interface mem_ctrl_if;
    logic [15:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;
    logic [7:0]  cpu_data_out;
    logic        cpu_write_en;
    logic        cpu_read_en;
    logic        busy;

    modport master (
        output cpu_addr_in, cpu_data_in, cpu_write_en, cpu_read_en,
        input  cpu_data_out, busy
    );

    modport slave (
        input  cpu_addr_in, cpu_data_in, cpu_write_en, cpu_read_en,
        output cpu_data_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Brief    : NES CPU bus decoder owning CPU/cart RAM, VRAM, palette, OAM and
//            PPU registers $2000-$2007. Define PALETTE_MIRROR_EN to alias
//            palette $3F10/$14/$18/$1C onto $3F00/$04/$08/$0C.
// Revision : 1.0
// ============================================================================
module mem_ctrl #(
    parameter int CPU_RAM_AW  = 11,
    parameter int CART_RAM_AW = 14,
    parameter int VRAM_AW     = 14
) (
    input  logic        clk,
    input  logic        rst,
    mem_ctrl_if.slave   cpu,
    output logic [7:0]  ppu_ctrl1,
    output logic [7:0]  ppu_ctrl2,
    input  logic [7:0]  ppu_status,
    output logic [15:0] ppu_scroll_addr,
    input  logic [15:0] vram_ppu_addr,
    output logic [7:0]  vram_ppu_data,
    input  logic [7:0]  spram_ppu_addr,
    output logic [7:0]  spram_ppu_data,
    output logic [7:0]  spram_cpu_addr,
    output logic        ppu_status_read
);
    localparam int c_VRAM_DEPTH = 12288;
    localparam logic [VRAM_AW-1:0] c_MIRROR_OFS = VRAM_AW'(16'h1000);

    logic [7:0] r_cpu_ram  [0:(2**CPU_RAM_AW)-1];
    logic [7:0] r_cart_ram [0:(2**CART_RAM_AW)-1];
    logic [7:0] r_vram     [0:c_VRAM_DEPTH-1];
    logic [7:0] r_pal      [0:31];
    logic [7:0] r_oam      [0:255];

    logic [VRAM_AW-1:0] r_vaddr;
    logic               r_toggle;

    function automatic logic f_is_pal(input logic [VRAM_AW-1:0] a);
        return &a[VRAM_AW-1:8];
    endfunction

    // $3000-$3EFF folds down onto the nametable area
    function automatic logic [VRAM_AW-1:0] f_vram_idx(input logic [VRAM_AW-1:0] a);
        return (a[VRAM_AW-1 -: 2] == 2'b11) ? a - c_MIRROR_OFS : a;
    endfunction

    function automatic logic [4:0] f_pal_idx(input logic [4:0] i);
`ifdef PALETTE_MIRROR_EN
        return (i[1:0] == 2'b00) ? {1'b0, i[3:0]} : i;
`else
        return i;
`endif
    endfunction

    logic               w_accept, w_wr, w_rd;
    logic               w_is_ram, w_is_reg, w_is_cart;
    logic [2:0]         w_sel;
    logic [VRAM_AW-1:0] w_cpu_vidx, w_ppu_vaddr, w_ppu_vidx;
    logic [4:0]         w_cpu_pidx, w_ppu_pidx;
    logic               w_cpu_vpal, w_ppu_vpal;
    logic [7:0]         w_reg_rdata;
    logic               w_unused;

    assign w_accept  = (cpu.cpu_write_en | cpu.cpu_read_en) & ~cpu.busy;
    assign w_wr      = w_accept & cpu.cpu_write_en;
    assign w_rd      = w_accept & ~cpu.cpu_write_en & cpu.cpu_read_en;
    assign w_is_ram  = (cpu.cpu_addr_in[15:13] == 3'b000);
    assign w_is_reg  = (cpu.cpu_addr_in[15:13] == 3'b001);
    assign w_is_cart = (cpu.cpu_addr_in[15:14] == 2'b01) && (cpu.cpu_addr_in[13:5] != 9'd0);
    assign w_sel     = cpu.cpu_addr_in[2:0];

    assign w_cpu_vidx  = f_vram_idx(r_vaddr);
    assign w_cpu_pidx  = f_pal_idx(r_vaddr[4:0]);
    assign w_cpu_vpal  = f_is_pal(r_vaddr);
    assign w_ppu_vaddr = vram_ppu_addr[VRAM_AW-1:0];
    assign w_ppu_vidx  = f_vram_idx(w_ppu_vaddr);
    assign w_ppu_pidx  = f_pal_idx(w_ppu_vaddr[4:0]);
    assign w_ppu_vpal  = f_is_pal(w_ppu_vaddr);
    assign w_unused    = ^vram_ppu_addr[15:VRAM_AW];

    always_comb begin
        w_reg_rdata = 8'h00;
        case (w_sel)
            3'd2:    w_reg_rdata = ppu_status;
            3'd4:    w_reg_rdata = r_oam[spram_cpu_addr];
            3'd7:    w_reg_rdata = w_cpu_vpal ? r_pal[w_cpu_pidx] : r_vram[w_cpu_vidx];
            default: w_reg_rdata = 8'h00;
        endcase
    end

    // Storage arrays carry no reset; a write is dropped while rst is high
    always_ff @(posedge clk) begin
        if (!rst && w_wr) begin
            if (w_is_ram) begin
                r_cpu_ram[cpu.cpu_addr_in[CPU_RAM_AW-1:0]] <= cpu.cpu_data_in;
            end else if (w_is_cart) begin
                r_cart_ram[cpu.cpu_addr_in[CART_RAM_AW-1:0]] <= cpu.cpu_data_in;
            end else if (w_is_reg) begin
                if (w_sel == 3'd4) begin
                    r_oam[spram_cpu_addr] <= cpu.cpu_data_in;
                end else if (w_sel == 3'd7) begin
                    if (w_cpu_vpal) r_pal[w_cpu_pidx]  <= cpu.cpu_data_in;
                    else            r_vram[w_cpu_vidx] <= cpu.cpu_data_in;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu.busy         <= 1'b0;
            cpu.cpu_data_out <= 8'h00;
            ppu_ctrl1        <= 8'h00;
            ppu_ctrl2        <= 8'h00;
            ppu_scroll_addr  <= 16'h0000;
            vram_ppu_data    <= 8'h00;
            spram_ppu_data   <= 8'h00;
            spram_cpu_addr   <= 8'h00;
            ppu_status_read  <= 1'b0;
            r_vaddr          <= '0;
            r_toggle         <= 1'b0;
        end else begin
            cpu.busy        <= w_accept;
            ppu_status_read <= 1'b0;
            vram_ppu_data   <= w_ppu_vpal ? r_pal[w_ppu_pidx] : r_vram[w_ppu_vidx];
            spram_ppu_data  <= r_oam[spram_ppu_addr];

            // RAM windows track the address every idle cycle; registers only on a read
            if (!cpu.busy) begin
                if (w_is_ram)       cpu.cpu_data_out <= r_cpu_ram[cpu.cpu_addr_in[CPU_RAM_AW-1:0]];
                else if (w_is_cart) cpu.cpu_data_out <= r_cart_ram[cpu.cpu_addr_in[CART_RAM_AW-1:0]];
                else if (!w_is_reg) cpu.cpu_data_out <= 8'h00;
                else if (w_rd)      cpu.cpu_data_out <= w_reg_rdata;
            end

            if (w_wr && w_is_reg) begin
                case (w_sel)
                    3'd0: ppu_ctrl1 <= cpu.cpu_data_in;
                    3'd1: ppu_ctrl2 <= cpu.cpu_data_in;
                    3'd3: spram_cpu_addr <= cpu.cpu_data_in;
                    3'd4: spram_cpu_addr <= spram_cpu_addr + 8'd1;
                    3'd5: begin
                        if (!r_toggle) ppu_scroll_addr[15:8] <= cpu.cpu_data_in;
                        else           ppu_scroll_addr[7:0]  <= cpu.cpu_data_in;
                        r_toggle <= ~r_toggle;
                    end
                    3'd6: begin
                        if (!r_toggle) r_vaddr <= {cpu.cpu_data_in[5:0], 8'h00};
                        else           r_vaddr[7:0] <= cpu.cpu_data_in;
                        r_toggle <= ~r_toggle;
                    end
                    3'd7: begin
                        r_vaddr  <= r_vaddr + 1'b1;
                        r_toggle <= 1'b0;
                    end
                    default: ;
                endcase
            end

            if (w_rd && w_is_reg) begin
                if (w_sel == 3'd2) begin
                    ppu_status_read <= 1'b1;
                    r_toggle        <= 1'b0;
                end else if (w_sel == 3'd7) begin
                    r_vaddr  <= r_vaddr + 1'b1;
                    r_toggle <= 1'b0;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Brief    : Directed self-checking bench for mem_ctrl
// Revision : 1.0
// ============================================================================
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ppu_ctrl1, ppu_ctrl2, ppu_status, vram_ppu_data;
    logic [7:0]  spram_ppu_addr, spram_ppu_data, spram_cpu_addr;
    logic [15:0] ppu_scroll_addr, vram_ppu_addr;
    logic        ppu_status_read;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mem_ctrl_if bus();

    mem_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .cpu             (bus),
        .ppu_ctrl1       (ppu_ctrl1),
        .ppu_ctrl2       (ppu_ctrl2),
        .ppu_status      (ppu_status),
        .ppu_scroll_addr (ppu_scroll_addr),
        .vram_ppu_addr   (vram_ppu_addr),
        .vram_ppu_data   (vram_ppu_data),
        .spram_ppu_addr  (spram_ppu_addr),
        .spram_ppu_data  (spram_ppu_data),
        .spram_cpu_addr  (spram_cpu_addr),
        .ppu_status_read (ppu_status_read)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access: request held for the accept cycle and the busy cycle
    task automatic acc(input logic [15:0] a, input logic [7:0] d, input logic w, input logic r);
        bus.cpu_addr_in  = a;
        bus.cpu_data_in  = d;
        bus.cpu_write_en = w;
        bus.cpu_read_en  = r;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.cpu_write_en = 1'b0;
        bus.cpu_read_en  = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        acc(a, d, 1'b1, 1'b0);
    endtask

    task automatic rd(input logic [15:0] a);
        acc(a, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic peek(input logic [15:0] a);
        bus.cpu_addr_in = a;
        @(posedge clk);
        #1;
    endtask

    task automatic set_vaddr(input logic [13:0] a);
        rd(16'h2002);
        wr(16'h2006, {2'b00, a[13:8]});
        wr(16'h2006, a[7:0]);
    endtask

    task automatic ppu_vr(input string tag, input logic [15:0] a, input logic [7:0] e);
        vram_ppu_addr = a;
        @(posedge clk);
        #1;
        check(tag, {8'h00, vram_ppu_data}, {8'h00, e});
    endtask

    function automatic logic [7:0] pal_exp(input int i);
        logic [7:0] v;
        v = i[7:0];
`ifdef PALETTE_MIRROR_EN
        if (v[1:0] == 2'b00 && v[4] == 1'b0) v = v | 8'h10;
`endif
        return v;
    endfunction

    initial begin
        #1_500_000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.cpu_addr_in = 16'h0000; bus.cpu_data_in = 8'h00;
        bus.cpu_write_en = 1'b0;    bus.cpu_read_en = 1'b0;
        ppu_status = 8'h00; vram_ppu_addr = 16'h0000; spram_ppu_addr = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_busy",   {15'h0, bus.busy}, 16'h0);
        check("rst_dout",   {8'h0, bus.cpu_data_out}, 16'h0);
        check("rst_ctrl1",  {8'h0, ppu_ctrl1}, 16'h0);
        check("rst_ctrl2",  {8'h0, ppu_ctrl2}, 16'h0);
        check("rst_scroll", ppu_scroll_addr, 16'h0);
        check("rst_oamptr", {8'h0, spram_cpu_addr}, 16'h0);
        check("rst_pulse",  {15'h0, ppu_status_read}, 16'h0);

        // Control registers, including a mirrored register address
        wr(16'h2000, 8'h80);
        wr(16'h2009, 8'h1E);
        check("ctrl1", {8'h0, ppu_ctrl1}, 16'h0080);
        check("ctrl2", {8'h0, ppu_ctrl2}, 16'h001E);

        // CPU RAM fill and readback with read enable low
        for (int i = 0; i < 2048; i++) wr(16'(i), 8'(i));
        for (int i = 0; i < 2048; i++) begin
            peek(16'(i));
            check("cpu_ram", {8'h0, bus.cpu_data_out}, 16'(i & 8'hFF));
        end
        peek(16'h0800); check("ram_mirror_0800", {8'h0, bus.cpu_data_out}, 16'h0000);
        peek(16'h1FFF); check("ram_mirror_1fff", {8'h0, bus.cpu_data_out}, 16'h00FF);

        // Cart RAM (strided), unmapped I/O and ROM windows
        for (int a = 16'h4020; a <= 16'h7FFE; a += 7) wr(16'(a), 8'(a));
        wr(16'h7FFE, 8'hFE);
        for (int a = 16'h4020; a <= 16'h7FFE; a += 7) begin
            peek(16'(a));
            check("cart_ram", {8'h0, bus.cpu_data_out}, 16'(a & 8'hFF));
        end
        peek(16'h7FFE); check("cart_top", {8'h0, bus.cpu_data_out}, 16'h00FE);
        wr(16'h4010, 8'h99);
        peek(16'h4010); check("io_read0", {8'h0, bus.cpu_data_out}, 16'h0000);
        wr(16'h9000, 8'h5A);
        peek(16'h9000); check("rom_read0", {8'h0, bus.cpu_data_out}, 16'h0000);

        // $2002 read: data, one-cycle pulse, toggle clear
        rd(16'h2002);
        wr(16'h2005, 8'h11);
        ppu_status = 8'hA5;
        bus.cpu_addr_in = 16'h2002; bus.cpu_read_en = 1'b1;
        @(posedge clk); #1;
        check("status_data",  {8'h0, bus.cpu_data_out}, 16'h00A5);
        check("status_pulse", {15'h0, ppu_status_read}, 16'h0001);
        check("status_busy",  {15'h0, bus.busy}, 16'h0001);
        @(posedge clk); #1;
        bus.cpu_read_en = 1'b0;
        check("status_pulse_end", {15'h0, ppu_status_read}, 16'h0000);
        wr(16'h2005, 8'h12);
        wr(16'h2005, 8'h34);
        check("scroll", ppu_scroll_addr, 16'h1234);

        // Write wins when both strobes are high: no toggle clear from $2002
        wr(16'h2005, 8'h56);
        acc(16'h2002, 8'h00, 1'b1, 1'b1);
        wr(16'h2005, 8'h78);
        check("write_priority", ppu_scroll_addr, 16'h5678);

        // OAM fill through $2004 and PPU-port readback
        wr(16'h2003, 8'h00);
        for (int i = 0; i < 256; i++) wr(16'h2004, 8'(i));
        check("oamptr_wrap", {8'h0, spram_cpu_addr}, 16'h0000);
        for (int i = 0; i < 256; i++) begin
            spram_ppu_addr = 8'(i);
            @(posedge clk); #1;
            check("oam_ppu", {8'h0, spram_ppu_data}, 16'(i));
        end
        wr(16'h2003, 8'h10);
        rd(16'h2004);
        check("oam_cpu_rd", {8'h0, bus.cpu_data_out}, 16'h0010);
        check("oam_no_inc", {8'h0, spram_cpu_addr}, 16'h0010);

        // VRAM fill through $2007
        set_vaddr(14'h0000);
        for (int i = 0; i < 16'h3000; i++) wr(16'h2007, 8'(i));
        set_vaddr(14'h0000);
        for (int i = 0; i < 64; i++) begin
            rd(16'h2007);
            check("vram_lo", {8'h0, bus.cpu_data_out}, 16'(i & 8'hFF));
        end
        set_vaddr(14'h2FC0);
        for (int i = 16'h2FC0; i < 16'h3000; i++) begin
            rd(16'h2007);
            check("vram_hi", {8'h0, bus.cpu_data_out}, 16'(i & 8'hFF));
        end

        // Mirror $3005 -> $2005 after a distinguishing write
        set_vaddr(14'h2005);
        wr(16'h2007, 8'hC3);
        set_vaddr(14'h3005);
        rd(16'h2007);
        check("vram_mirror_cpu", {8'h0, bus.cpu_data_out}, 16'h00C3);
        ppu_vr("vram_mirror_ppu", 16'h3005, 8'hC3);
        ppu_vr("vram_ppu_plain", 16'h0123, 8'h23);

        // Same-cycle CPU write / PPU read returns old data
        set_vaddr(14'h0040);
        vram_ppu_addr = 16'h0040;
        bus.cpu_addr_in = 16'h2007; bus.cpu_data_in = 8'hEE; bus.cpu_write_en = 1'b1;
        @(posedge clk); #1;
        check("dualport_old", {8'h0, vram_ppu_data}, 16'h0040);
        @(posedge clk); #1;
        bus.cpu_write_en = 1'b0;
        check("dualport_new", {8'h0, vram_ppu_data}, 16'h00EE);

        // Palette
        set_vaddr(14'h3F00);
        for (int i = 0; i < 32; i++) wr(16'h2007, 8'(i));
        set_vaddr(14'h3F00);
        for (int i = 0; i < 32; i++) begin
            rd(16'h2007);
            check("palette", {8'h0, bus.cpu_data_out}, {8'h0, pal_exp(i)});
        end
        ppu_vr("pal_ppu", 16'h3F05, 8'h05);
        ppu_vr("pal_ppu_mask", 16'h7F05, 8'h05);

        // $3FFF write wraps the pointer to $0000
        set_vaddr(14'h3FFF);
        wr(16'h2007, 8'h77);
        rd(16'h2007);
        check("vaddr_wrap", {8'h0, bus.cpu_data_out}, 16'h0000);
        ppu_vr("pal_1f", 16'h3F1F, 8'h77);

        // Asynchronous reset in the middle of an access
        wr(16'h2000, 8'h55);
        wr(16'h2003, 8'h42);
        bus.cpu_addr_in = 16'h2001; bus.cpu_data_in = 8'h33; bus.cpu_write_en = 1'b1;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_busy",   {15'h0, bus.busy}, 16'h0);
        check("arst_ctrl1",  {8'h0, ppu_ctrl1}, 16'h0);
        check("arst_ctrl2",  {8'h0, ppu_ctrl2}, 16'h0);
        check("arst_scroll", ppu_scroll_addr, 16'h0);
        check("arst_oamptr", {8'h0, spram_cpu_addr}, 16'h0);
        bus.cpu_write_en = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
